i2c_slave_ctrl_mc: RTL

- Next-generation I2C slave control FSM.
- Generalises the single-address slave controller to NUM_ADDR address slots, each 7- or 10-bit, with optional general-call acceptance.
- Adds a clock-stretch timeout, an RX byte limit that forces NACK, a per-transaction byte counter, and START/STOP abort from every active state.
- Sits between the SDA/SCL edge detectors, address comparators, shift registers and the TX/RX FIFOs.

---
 rtl/i2c_slave_ctrl_mc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl_mc.sv
// I2C slave control FSM: multi-slot 7/10-bit addressing, general call, RX byte limit,
// clock-stretch timeout and START/STOP abort. All outputs are registered.
module i2c_slave_ctrl_mc #(
  parameter int unsigned     NUM_ADDR        = 4,
  parameter int unsigned     SLOT_W          = 2,
  parameter int unsigned     BCNT_W          = 8,
  parameter int unsigned     TO_W            = 16,
  parameter logic [TO_W-1:0] STRETCH_TIMEOUT = 16'd50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                rw_mode,
  input  logic                SDA_sync,
  input  logic                ack_prep,
  input  logic                ack_check,
  input  logic                ack_done,
  input  logic [NUM_ADDR-1:0] addr_match_1,
  input  logic [NUM_ADDR-1:0] addr_match_2,
  input  logic [NUM_ADDR-1:0] slot_10bit,
  input  logic                gc_enable,
  input  logic                gc_detect,
  input  logic                TX_fifo_empty,
  input  logic                RX_fifo_full,
  input  logic                en_clock_strech,
  input  logic [BCNT_W-1:0]   max_rx_bytes,
  output logic                rx_enable,
  output logic                SCL_out_slave,
  output logic                busy_slave,
  output logic                TX_read_enable_slave,
  output logic                RX_write_enable_slave,
  output logic                ack_error_set_slave,
  output logic [1:0]          sda_mode,
  output logic                load_data,
  output logic                tx_enable,
  output logic                rw_store,
  output logic [SLOT_W-1:0]   matched_slot,
  output logic                general_call,
  output logic [BCNT_W-1:0]   byte_count,
  output logic                stretch_timeout_err
);

  localparam int unsigned IDX_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  typedef enum logic [4:0] {
    IDLE, GET_ADDR_1, CHECK_ADDR_1, NO_MATCH, ACK_SEND_1, GET_ADDR_2, CHECK_ADDR_2,
    ACK_SEND_2, FIFO_CHK_TX, STRETCH_TX, LOAD, DATA_TX, DATA_WAIT, ACK_CHECK, RE_ACK,
    RE_NACK, FIFO_CHK_RX, RX_BYTE, SEND_ACK, SEND_NACK, RX_WRITE, RX_DROP, TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic              nack_entry_q, to_entry_q;
  logic              gc_hit_c, hit_c, ten_c, hold_c, timeout_c, limit_c, clr_c;
  logic [SLOT_W-1:0] slot_c;
  logic              rx_enable_d, scl_d, busy_d, tx_rd_d, rx_wr_d, load_d, tx_en_d, rw_store_d;
  logic [1:0]        sda_mode_d;

  // Next state and Moore output decode of the current state
  always_comb begin
    state_d     = state_q;
    gc_hit_c    = gc_enable & gc_detect & ~rw_mode;
    hit_c       = 1'b0;
    ten_c       = 1'b0;
    slot_c      = '0;
    rx_enable_d = 1'b0;
    busy_d      = (state_q != IDLE);
    tx_rd_d     = 1'b0;
    rx_wr_d     = 1'b0;
    load_d      = 1'b0;
    tx_en_d     = 1'b0;
    rw_store_d  = 1'b0;
    sda_mode_d  = 2'b00;

    // Lowest-index matching slot wins
    for (int unsigned i = 0; i < NUM_ADDR; i++) begin
      if (!hit_c && addr_match_1[IDX_W'(i)]) begin
        hit_c  = 1'b1;
        ten_c  = slot_10bit[IDX_W'(i)];
        slot_c = SLOT_W'(i);
      end
    end

    hold_c    = (state_q == FIFO_CHK_TX) || (state_q == STRETCH_TX) ||
                ((state_q == FIFO_CHK_RX) && en_clock_strech && RX_fifo_full);
    timeout_c = (STRETCH_TIMEOUT != '0) && hold_c && (to_cnt_q == STRETCH_TIMEOUT - TO_W'(1));
    limit_c   = (max_rx_bytes != '0) && (byte_count >= max_rx_bytes);
    scl_d     = ~hold_c;

    unique case (state_q)
      IDLE:         if (start) state_d = GET_ADDR_1;
      GET_ADDR_1: begin
        rx_enable_d = 1'b1;
        rw_store_d  = 1'b1;
        if (ack_prep) state_d = CHECK_ADDR_1;
      end
      CHECK_ADDR_1: begin
        if (gc_hit_c)   state_d = ACK_SEND_2;
        else if (hit_c) state_d = ten_c ? ACK_SEND_1 : ACK_SEND_2;
        else            state_d = NO_MATCH;
      end
      NO_MATCH: begin
        sda_mode_d = 2'b10;
        if (ack_done) state_d = IDLE;
      end
      ACK_SEND_1: begin
        sda_mode_d = 2'b01;
        if (ack_done) state_d = GET_ADDR_2;
      end
      GET_ADDR_2: begin
        rx_enable_d = 1'b1;
        if (ack_prep) state_d = CHECK_ADDR_2;
      end
      CHECK_ADDR_2: state_d = addr_match_2[IDX_W'(matched_slot)] ? ACK_SEND_2 : NO_MATCH;
      ACK_SEND_2: begin
        sda_mode_d = 2'b01;
        if (ack_done) state_d = rw_mode ? FIFO_CHK_TX : FIFO_CHK_RX;
      end
      FIFO_CHK_TX, STRETCH_TX:
        state_d = (en_clock_strech && TX_fifo_empty) ? STRETCH_TX : LOAD;
      LOAD: begin
        load_d  = 1'b1;
        state_d = DATA_TX;
      end
      DATA_TX: begin
        sda_mode_d = 2'b11;
        tx_en_d    = 1'b1;
        if (ack_prep) state_d = DATA_WAIT;
      end
      DATA_WAIT:    if (ack_check) state_d = ACK_CHECK;
      ACK_CHECK: begin
        tx_rd_d = 1'b1;
        state_d = SDA_sync ? RE_NACK : RE_ACK;
      end
      RE_ACK:       if (ack_done) state_d = FIFO_CHK_TX;
      RE_NACK:      state_d = RE_NACK;
      FIFO_CHK_RX:  if (!(en_clock_strech && RX_fifo_full)) state_d = RX_BYTE;
      RX_BYTE: begin
        rx_enable_d = 1'b1;
        if (ack_prep) state_d = (RX_fifo_full || limit_c) ? SEND_NACK : SEND_ACK;
      end
      SEND_ACK: begin
        sda_mode_d = 2'b01;
        if (ack_done) state_d = RX_WRITE;
      end
      SEND_NACK: begin
        sda_mode_d = 2'b10;
        if (ack_done) state_d = RX_DROP;
      end
      RX_WRITE: begin
        rx_wr_d = 1'b1;
        state_d = FIFO_CHK_RX;
      end
      RX_DROP:      state_d = RX_BYTE;
      TIMEOUT:      state_d = TIMEOUT;
      default:      state_d = IDLE;
    endcase

    // Bus conditions override everything once a transaction is active
    if (state_q != IDLE) begin
      if (stop)           state_d = IDLE;
      else if (start)     state_d = GET_ADDR_1;
      else if (timeout_c) state_d = TIMEOUT;
    end

    clr_c = (state_d == IDLE) || (state_d == GET_ADDR_1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      to_cnt_q              <= '0;
      nack_entry_q          <= 1'b0;
      to_entry_q            <= 1'b0;
      rx_enable             <= 1'b0;
      SCL_out_slave         <= 1'b1;
      busy_slave            <= 1'b0;
      TX_read_enable_slave  <= 1'b0;
      RX_write_enable_slave <= 1'b0;
      ack_error_set_slave   <= 1'b0;
      sda_mode              <= 2'b00;
      load_data             <= 1'b0;
      tx_enable             <= 1'b0;
      rw_store              <= 1'b0;
      matched_slot          <= '0;
      general_call          <= 1'b0;
      byte_count            <= '0;
      stretch_timeout_err   <= 1'b0;
    end else begin
      state_q               <= state_d;
      to_cnt_q              <= hold_c ? to_cnt_q + TO_W'(1) : '0;
      nack_entry_q          <= (state_d == SEND_NACK) && (state_q != SEND_NACK);
      to_entry_q            <= (state_d == TIMEOUT) && (state_q != TIMEOUT);
      rx_enable             <= rx_enable_d;
      SCL_out_slave         <= scl_d;
      busy_slave            <= busy_d;
      TX_read_enable_slave  <= tx_rd_d;
      RX_write_enable_slave <= rx_wr_d;
      ack_error_set_slave   <= nack_entry_q;
      sda_mode              <= sda_mode_d;
      load_data             <= load_d;
      tx_enable             <= tx_en_d;
      rw_store              <= rw_store_d;
      stretch_timeout_err   <= to_entry_q;
      if (state_q == CHECK_ADDR_1 && !gc_hit_c && hit_c) matched_slot <= slot_c;
      if (clr_c)
        general_call <= 1'b0;
      else if (state_q == CHECK_ADDR_1 && gc_hit_c && state_d == ACK_SEND_2)
        general_call <= 1'b1;
      // Saturating count of completed data bytes
      if (clr_c)
        byte_count <= '0;
      else if ((state_q == ACK_CHECK || state_q == RX_WRITE) && byte_count != '1)
        byte_count <= byte_count + BCNT_W'(1);
    end
  end

endmodule
